// File: rtl/cache_line_fill_stage_pkg.sv
// Shared cache configuration for the line-fill path: geometry widths and the
// fill-stage state encoding.
package cache_line_fill_stage_pkg;

    localparam int SET_ADDR_WDTH       = 6;
    localparam int C_N_WAY             = 4;
    localparam int AXI_CACHE_DATA_WDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/cache_line_fill_stage.sv
// Cache line fill stage: pops a miss element, streams one line of AXI R beats
// into the cache data RAM, then holds a completion until it is accepted.
// Optional macro FILL_BEAT_CHECK_EN adds a sticky RLAST/beat-count error flag.
module cache_line_fill_stage
    import cache_line_fill_stage_pkg::*;
#(
    parameter int BEATS_PER_LINE = 8,
    parameter int BEAT_CNT_WDTH  = 3
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           miss_elem_fifo_empty,
    input  logic [SET_ADDR_WDTH-1:0]                       miss_elem_set_addr,
    input  logic [C_N_WAY-1:0]                             miss_elem_set_idx,
    output logic                                           miss_elem_fifo_rd_en,
    input  logic                                           ref_pix_axi_rvalid,
    input  logic [AXI_CACHE_DATA_WDTH-1:0]                 ref_pix_axi_rdata,
    input  logic                                           ref_pix_axi_rlast,
    output logic                                           ref_pix_axi_rready,
    output logic                                           cache_wr_en,
    output logic [SET_ADDR_WDTH+C_N_WAY+BEAT_CNT_WDTH-1:0] cache_wr_addr,
    output logic [AXI_CACHE_DATA_WDTH-1:0]                 cache_wr_data,
    output logic                                           fill_done_valid,
    input  logic                                           fill_done_ready,
    output logic [SET_ADDR_WDTH-1:0]                       fill_done_set_addr,
    output logic [C_N_WAY-1:0]                             fill_done_set_idx,
    output logic                                           fill_err
);

    localparam logic [BEAT_CNT_WDTH-1:0] LAST_BEAT = BEAT_CNT_WDTH'(BEATS_PER_LINE - 1);

    fill_state_t               state;
    fill_state_t               state_nxt;
    logic [BEAT_CNT_WDTH-1:0]  beat_cnt;
    logic [SET_ADDR_WDTH-1:0]  set_addr_q;
    logic [C_N_WAY-1:0]        set_idx_q;
    logic                      beat_hs;
    logic                      last_beat;

    assign beat_hs   = ref_pix_axi_rvalid & ref_pix_axi_rready;
    assign last_beat = (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (miss_elem_fifo_rd_en)     state_nxt = ST_FILL;
            ST_FILL: if (beat_hs && last_beat)     state_nxt = ST_DONE;
            ST_DONE: if (fill_done_ready)          state_nxt = ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    // Pop and R-ready are gated by reset so nothing is consumed in the reset cycle.
    always_comb begin
        miss_elem_fifo_rd_en = 1'b0;
        ref_pix_axi_rready   = 1'b0;
        fill_done_valid      = 1'b0;
        case (state)
            ST_IDLE: miss_elem_fifo_rd_en = ~miss_elem_fifo_empty & ~reset;
            ST_FILL: ref_pix_axi_rready   = ~reset;
            ST_DONE: fill_done_valid      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt      <= '0;
            set_addr_q    <= '0;
            set_idx_q     <= '0;
            cache_wr_en   <= 1'b0;
            cache_wr_addr <= '0;
            cache_wr_data <= '0;
        end else begin
            cache_wr_en <= beat_hs;
            if (miss_elem_fifo_rd_en) begin
                set_addr_q <= miss_elem_set_addr;
                set_idx_q  <= miss_elem_set_idx;
                beat_cnt   <= '0;
            end
            // Counter saturates on the final beat so it never wraps within a line.
            if (beat_hs) begin
                cache_wr_addr <= {set_addr_q, set_idx_q, beat_cnt};
                cache_wr_data <= ref_pix_axi_rdata;
                if (!last_beat) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    assign fill_done_set_addr = set_addr_q;
    assign fill_done_set_idx  = set_idx_q;

`ifdef FILL_BEAT_CHECK_EN
    logic fill_err_q;

    // RLAST must coincide exactly with the final beat of the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_err_q <= 1'b0;
        end else if (beat_hs && (ref_pix_axi_rlast != last_beat)) begin
            fill_err_q <= 1'b1;
        end
    end

    assign fill_err = fill_err_q;
`else
    logic unused_rlast;

    assign unused_rlast = ref_pix_axi_rlast;
    assign fill_err     = 1'b0;
`endif

endmodule
